// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

   localparam int unsigned MEM_WAIT_MAX = 15;
   localparam int unsigned WAIT_W       = 4;

   typedef enum logic [2:0] {
      StHalt     = 3'd0,
      StF1       = 3'd1,
      StF2       = 3'd2,
      StF3       = 3'd3,
      StExec     = 3'd4,
      StPause    = 3'd5,
      StPauseRel = 3'd6
   } fetch_state_t;

endpackage

// File: rtl/fetch_wait_timer.sv
// Loadable down-counter that times the memory read in the F2 state.
module fetch_wait_timer
   import fetch_pkg::*;
(
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_load,
   input  logic [WAIT_W-1:0] i_value,
   input  logic              i_dec,
   output logic              o_zero
);

   logic [WAIT_W-1:0] r_count;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_value;
      end else if (i_dec && (r_count != '0)) begin
         r_count <= r_count - 1'b1;
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-side control FSM: owns the bus gates and fetch load enables.
// Moore machine; outputs decode from state and wait counter only.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int unsigned MEM_WAIT    = 2,
   parameter bit          SINGLE_STEP = 1'b1
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       Run,
   input  logic       Continue,
   input  logic       exec_done,
   output logic       GatePC,
   output logic       GateMDR,
   output logic       LD_MAR,
   output logic       LD_PC,
   output logic       pc_inc,
   output logic       Mem_OE,
   output logic       LD_MDR,
   output logic       LD_IR,
   output logic       instr_valid,
   output logic [2:0] state_dbg
);

   fetch_state_t r_state;
   fetch_state_t w_state_next;
   logic         w_wait_zero;

   // Counter is primed in F1 so the first F2 cycle already sees MEM_WAIT-1.
   fetch_wait_timer u_wait_timer (
      .i_clk   (Clk),
      .i_reset (Reset),
      .i_load  (r_state == StF1),
      .i_value (WAIT_W'(MEM_WAIT - 1)),
      .i_dec   (r_state == StF2),
      .o_zero  (w_wait_zero)
   );

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         StHalt:     if (Run) w_state_next = StF1;
         StF1:       w_state_next = StF2;
         StF2:       if (w_wait_zero) w_state_next = StF3;
         StF3:       w_state_next = StExec;
         StExec: begin
            if (exec_done) begin
               if (SINGLE_STEP)  w_state_next = StPause;
               else if (Run)     w_state_next = StF1;
               else              w_state_next = StHalt;
            end
         end
         StPause:    if (Continue) w_state_next = StPauseRel;
         // Waiting for button release gives one instruction per press.
         StPauseRel: if (!Continue) w_state_next = Run ? StF1 : StHalt;
         default:    w_state_next = StHalt;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         r_state <= StHalt;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      GatePC      = 1'b0;
      GateMDR     = 1'b0;
      LD_MAR      = 1'b0;
      LD_PC       = 1'b0;
      pc_inc      = 1'b0;
      Mem_OE      = 1'b1;
      LD_MDR      = 1'b0;
      LD_IR       = 1'b0;
      instr_valid = 1'b0;
      case (r_state)
         StF1: begin
            GatePC = 1'b1;
            LD_MAR = 1'b1;
            LD_PC  = 1'b1;
            pc_inc = 1'b1;
         end
         StF2: begin
            Mem_OE = 1'b0;
            LD_MDR = w_wait_zero;
         end
         StF3: begin
            GateMDR = 1'b1;
            LD_IR   = 1'b1;
         end
         StExec:  instr_valid = 1'b1;
         default: ;
      endcase
   end

   assign state_dbg = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench: four parameterisations share one stimulus stream and
// are compared every cycle against a fetch-position reference model.
module tb_fetch_sequencer;

   localparam int NI = 4;

   localparam logic [11:0] E_HALT = 12'h008;
   localparam logic [11:0] E_F1   = 12'h378;
   localparam logic [11:0] E_F2A  = 12'h400;
   localparam logic [11:0] E_F2B  = 12'h404;
   localparam logic [11:0] E_F3   = 12'h68A;
   localparam logic [11:0] E_EXEC = 12'h809;

   localparam int M_HALT = 0, M_FETCH = 1, M_EXEC = 2, M_PAUSE = 3, M_PREL = 4;

   function automatic int mw_of(int i);
      case (i)
         0: return 2;
         1: return 2;
         2: return 1;
         default: return 15;
      endcase
   endfunction

   function automatic bit ss_of(int i);
      return (i == 1);
   endfunction

   logic clk, rst, run, cont, done;
   logic [NI-1:0] gpc, gmdr, ldmar, ldpc, pcinc, moe, ldmdr, ldir, iv;
   logic [2:0]    dbg [NI];

   for (genvar g = 0; g < NI; g++) begin : g_dut
      fetch_sequencer #(
         .MEM_WAIT    (mw_of(g)),
         .SINGLE_STEP (ss_of(g))
      ) u_dut (
         .Clk         (clk),
         .Reset       (rst),
         .Run         (run),
         .Continue    (cont),
         .exec_done   (done),
         .GatePC      (gpc[g]),
         .GateMDR     (gmdr[g]),
         .LD_MAR      (ldmar[g]),
         .LD_PC       (ldpc[g]),
         .pc_inc      (pcinc[g]),
         .Mem_OE      (moe[g]),
         .LD_MDR      (ldmdr[g]),
         .LD_IR       (ldir[g]),
         .instr_valid (iv[g]),
         .state_dbg   (dbg[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Model: mode plus position k within the fetch (0=F1, 1..MW=wait, MW+1=IR load).
   int m_mode [NI];
   int m_k    [NI];

   function automatic logic [11:0] obs(int i);
      return {dbg[i], gpc[i], gmdr[i], ldmar[i], ldpc[i], pcinc[i], moe[i], ldmdr[i], ldir[i],
              iv[i]};
   endfunction

   function automatic logic [11:0] exp_of(int i);
      case (m_mode[i])
         M_FETCH: begin
            if (m_k[i] == 0) return {3'd1, 9'b101111000};
            if (m_k[i] <= mw_of(i)) return {3'd2, 6'b000000, (m_k[i] == mw_of(i)), 2'b00};
            return {3'd3, 9'b010001010};
         end
         M_EXEC:  return {3'd4, 9'b000001001};
         M_PAUSE: return {3'd5, 9'b000001000};
         M_PREL:  return {3'd6, 9'b000001000};
         default: return {3'd0, 9'b000001000};
      endcase
   endfunction

   task automatic model_step(int i);
      if (rst) begin
         m_mode[i] = M_HALT;
         m_k[i]    = 0;
      end else begin
         case (m_mode[i])
            M_HALT: if (run) begin m_mode[i] = M_FETCH; m_k[i] = 0; end
            M_FETCH: begin
               if (m_k[i] == mw_of(i) + 1) m_mode[i] = M_EXEC;
               else m_k[i] = m_k[i] + 1;
            end
            M_EXEC: if (done) begin
               if (ss_of(i)) m_mode[i] = M_PAUSE;
               else if (run) begin m_mode[i] = M_FETCH; m_k[i] = 0; end
               else m_mode[i] = M_HALT;
            end
            M_PAUSE: if (cont) m_mode[i] = M_PREL;
            default: if (!cont) begin
               if (run) begin m_mode[i] = M_FETCH; m_k[i] = 0; end
               else m_mode[i] = M_HALT;
            end
         endcase
      end
   endtask

   task automatic chk(string name, int got, int exp);
      n_vec++;
      if (got != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      for (int i = 0; i < NI; i++) model_step(i);
      #1;
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("model dut%0d", i), 32'(obs(i)), 32'(exp_of(i)));
         chk($sformatf("gate_exclusive dut%0d", i), 32'(gpc[i] & gmdr[i]), 0);
         chk($sformatf("mar_vs_mdr dut%0d", i), 32'(ldmar[i] & gmdr[i]), 0);
      end
   endtask

   typedef struct packed {
      logic        rs;
      logic        ru;
      logic        co;
      logic        dn;
      logic [11:0] e;
   } vec_t;

   function automatic vec_t mk(logic rs, logic ru, logic co, logic dn, logic [11:0] e);
      vec_t v;
      v.rs = rs; v.ru = ru; v.co = co; v.dn = dn; v.e = e;
      return v;
   endfunction

   vec_t tab [22];

   initial begin
      int n_ir;
      int acc;
      int lowcnt [NI];
      int mdr_at [NI];

      for (int i = 0; i < NI; i++) begin m_mode[i] = M_HALT; m_k[i] = 0; end
      rst = 1'b1; run = 1'b1; cont = 1'b0; done = 1'b0;

      // Reset with Run high, then three back-to-back instructions on dut0.
      tab[0]  = mk(1, 1, 0, 0, E_HALT);  tab[1]  = mk(1, 1, 0, 0, E_HALT);
      tab[2]  = mk(0, 1, 0, 0, E_F1);    tab[3]  = mk(0, 1, 0, 0, E_F2A);
      tab[4]  = mk(0, 1, 0, 0, E_F2B);   tab[5]  = mk(0, 1, 0, 0, E_F3);
      tab[6]  = mk(0, 1, 0, 0, E_EXEC);  tab[7]  = mk(0, 1, 0, 0, E_EXEC);
      tab[8]  = mk(0, 1, 0, 1, E_F1);    tab[9]  = mk(0, 1, 0, 0, E_F2A);
      tab[10] = mk(0, 1, 0, 0, E_F2B);   tab[11] = mk(0, 1, 0, 0, E_F3);
      tab[12] = mk(0, 1, 0, 0, E_EXEC);  tab[13] = mk(0, 1, 0, 0, E_EXEC);
      tab[14] = mk(0, 1, 0, 1, E_F1);    tab[15] = mk(0, 1, 0, 0, E_F2A);
      tab[16] = mk(0, 1, 0, 0, E_F2B);   tab[17] = mk(0, 1, 0, 0, E_F3);
      tab[18] = mk(0, 1, 0, 0, E_EXEC);  tab[19] = mk(0, 1, 0, 0, E_EXEC);
      tab[20] = mk(0, 0, 0, 1, E_HALT);  tab[21] = mk(0, 0, 0, 0, E_HALT);

      n_ir = 0;
      for (int r = 0; r < 22; r++) begin
         rst = tab[r].rs; run = tab[r].ru; cont = tab[r].co; done = tab[r].dn;
         cycle();
         chk($sformatf("table row %0d", r), 32'(obs(0)), 32'(tab[r].e));
         if (ldir[0]) n_ir++;
      end
      chk("ld_ir_count_3_instr", n_ir, 3);

      // Single step: dut1 parked in PAUSE; held Continue sits in PAUSE_REL.
      chk("ss_paused", 32'(dbg[1]), 5);
      run = 1'b1; cont = 1'b1; done = 1'b0;
      acc = 0;
      for (int c = 0; c < 10; c++) begin
         cycle();
         chk("ss_held_in_pause_rel", 32'(dbg[1]), 6);
         acc += 32'(ldir[1]);
      end
      chk("ss_no_fetch_while_held", acc, 0);
      cont = 1'b0; done = 1'b1;
      acc = 0;
      for (int c = 0; c < 12; c++) begin
         cycle();
         acc += 32'(ldir[1]);
      end
      chk("ss_one_fetch_after_release", acc, 1);
      chk("ss_back_in_pause", 32'(dbg[1]), 5);

      // Run dropped in F2: fetch completes, then HALT with no further LD_MAR.
      rst = 1'b1; done = 1'b0; cycle();
      rst = 1'b0; run = 1'b1; cycle(); cycle();
      run = 1'b0; cycle(); cycle();
      chk("rundrop_f3", 32'(dbg[0]), 3);
      cycle();
      chk("rundrop_exec", 32'(iv[0]), 1);
      done = 1'b1; cycle();
      chk("rundrop_halt", 32'(dbg[0]), 0);
      done = 1'b0;
      acc = 0;
      for (int c = 0; c < 5; c++) begin cycle(); acc += 32'(ldmar[0]); end
      chk("rundrop_no_ld_mar", acc, 0);

      // Reset in the second F2 cycle aborts the fetch.
      rst = 1'b1; cycle();
      rst = 1'b0; run = 1'b1; cycle(); cycle(); cycle();
      chk("abort_in_f2b", 32'(obs(0)), 32'(E_F2B));
      rst = 1'b1; cycle();
      chk("abort_state", 32'(dbg[0]), 0);
      chk("abort_no_ld_mdr", 32'(ldmdr[0]), 0);
      rst = 1'b0; run = 1'b0;
      acc = 0;
      for (int c = 0; c < 4; c++) begin cycle(); acc += 32'(ldir[0] | ldmdr[0]); end
      chk("abort_no_loads", acc, 0);

      // Wait-state extremes: dut2 (MEM_WAIT=1) and dut3 (MEM_WAIT=15).
      rst = 1'b1; cycle();
      rst = 1'b0; run = 1'b1; done = 1'b0;
      for (int i = 0; i < NI; i++) begin lowcnt[i] = 0; mdr_at[i] = 0; end
      for (int c = 0; c < 25; c++) begin
         cycle();
         for (int i = 2; i < NI; i++) begin
            if (!moe[i]) lowcnt[i]++;
            if (ldmdr[i]) mdr_at[i] = moe[i] ? -1 : lowcnt[i];
         end
      end
      for (int i = 2; i < NI; i++) begin
         chk($sformatf("mem_oe_low_len dut%0d", i), lowcnt[i], mw_of(i));
         chk($sformatf("ld_mdr_last_wait dut%0d", i), mdr_at[i], mw_of(i));
      end

      // Random traffic against the reference model.
      for (int c = 0; c < 400; c++) begin
         rst  = ($urandom_range(39) == 0);
         run  = ($urandom_range(3) != 0);
         cont = ($urandom_range(2) == 0);
         done = ($urandom_range(2) == 0);
         cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
Control sequencer that owns the shared 16-bit datapath bus and the fetch-side load enables. It walks the instruction-fetch sequence MAR<-PC, PC<-PC+1; MDR<-M(MAR) with memory wait states; IR<-MDR. It then hands the instruction to the execute unit and optionally pauses for single-step. It is the only driver of GatePC/GateMDR and guarantees that at most one gate is active in any cycle.

Parameters:
MEM_WAIT, 2, memory read latency in cycles; Mem_OE held this long before the MDR load; legal range 1..15
SINGLE_STEP, 1, 1 = enter PAUSE after every instruction; 0 = free-run

Ports:
Clk  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high
Run  in  1  level; start/keep fetching
Continue  in  1  level button; resumes from PAUSE
exec_done  in  1  execute unit finished current instruction (single-cycle pulse or level)
GatePC  out  1  drive PC onto bus
GateMDR  out  1  drive MDR onto bus
LD_MAR  out  1  load MAR from bus
LD_PC  out  1  load PC (with pc_inc)
pc_inc  out  1  PC mux selects PC+1
Mem_OE  out  1  memory output enable, active-low
LD_MDR  out  1  load MDR from memory
LD_IR  out  1  load IR from bus
instr_valid  out  1  IR holds a fetched instruction awaiting execution
state_dbg  out  3  encoded current state, for hex display

Behaviour:
- Registered Moore FSM. All outputs decode from the current state and the wait counter only; no input-to-output combinational path.
- Reset (sync, priority over everything):
  - state=HALT, wait counter=0.
  - All outputs 0 except Mem_OE=1 (deasserted); state_dbg=0.
  - Reset mid-fetch aborts the fetch; no LD_* pulse occurs in the cycle after Reset is sampled.
- States and encodings: HALT=0, F1=1, F2=2, F3=3, EXEC=4, PAUSE=5, PAUSE_REL=6.
- HALT:
  - Outputs idle.
  - Run=1 -> F1, else stay.
- F1 (1 cycle):
  - GatePC=1, LD_MAR=1, LD_PC=1, pc_inc=1.
  - -> F2, wait counter loads MEM_WAIT-1.
- F2 (MEM_WAIT cycles):
  - Mem_OE=0 for every F2 cycle.
  - LD_MDR=1 only in the final F2 cycle (counter==0).
  - Counter decrements each cycle; at 0 -> F3.
- F3 (1 cycle):
  - GateMDR=1, LD_IR=1.
  - -> EXEC.
- EXEC:
  - instr_valid=1; all gates and loads 0.
  - Wait for exec_done=1.
  - On exec_done=1: SINGLE_STEP=1 -> PAUSE; else Run=1 -> F1; else HALT.
- PAUSE:
  - Idle outputs.
  - Continue=1 -> PAUSE_REL.
- PAUSE_REL:
  - Idle outputs.
  - Continue=0 -> F1 if Run=1, else HALT.
  - A held button therefore yields exactly one instruction.
- Latency: Run sampled high in HALT -> instr_valid high after 1+MEM_WAIT+1+1 cycles (5 at default).
- Run dropping mid-fetch (F1..F3) does not abort; the instruction completes and EXEC then goes to HALT.
- exec_done outside EXEC is ignored.
- Invariant: GatePC & GateMDR never both 1; LD_MAR never with GateMDR.
- An illegal state encoding recovers to HALT next cycle with idle outputs.

Decomposition:
- Package fetch_pkg:
  - state enum fetch_state_t (3-bit, encodings above).
  - Constant MEM_WAIT_MAX=15.
  - Counter width localparam WAIT_W=4.
- One sub-module, fetch_wait_timer:
  - Loadable down-counter (load, value, decrement, zero flag).
  - Instantiated for the F2 wait; reset to 0.

Test Plan:
1. Reset=1 for 2 cycles with Run=1 -> state_dbg=0, Mem_OE=1, all other outputs 0; first F1 occurs the cycle after Reset falls.
2. MEM_WAIT=2, SINGLE_STEP=0, Run=1, exec_done pulsed 1 cycle after instr_valid rises -> per-cycle trace:
   - F1 (GatePC, LD_MAR, LD_PC)
   - F2 (Mem_OE=0)
   - F2 (Mem_OE=0, LD_MDR)
   - F3 (GateMDR, LD_IR)
   - EXEC
   - Then F1 again; 3 consecutive instructions give exactly 3 LD_IR pulses.
3. SINGLE_STEP=1, Continue held high 10 cycles, then low -> exactly one additional fetch (one LD_IR) after release; the FSM sits in PAUSE_REL while held.
4. Run dropped during F2 -> F3 and EXEC still occur; after exec_done, state_dbg=0 (HALT); no further LD_MAR.
5. Reset asserted in the second F2 cycle -> no LD_MDR and no LD_IR pulse follow; state_dbg=0 next cycle.
6. MEM_WAIT=1 and MEM_WAIT=15 -> Mem_OE=0 for exactly 1 and 15 cycles; LD_MDR coincides with the last one. Assertion over all tests: GatePC & GateMDR never 1.
